q2_lcd_ctrl: RTL

Synthesizable HD44780 character-LCD driver that consumes the q2 output-port writes (`wr` strobe plus 12-bit `dbus`) and drives a physical 8-bit LCD bus. It decodes the same command/data encoding as the simulation display model, buffers writes in a small FIFO, runs the power-on init sequence, and generates the E-strobe and post-command wait timing. Sits directly downstream of the CPU output port and replaces the display model on hardware.

---
 rtl/q2_lcd_pkg.sv | 54 +++++
 rtl/q2_lcd_fifo.sv | 61 ++++++
 rtl/q2_lcd_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/q2_lcd_pkg.sv
// Shared types and constants for the q2 HD44780 character-LCD driver.
package q2_lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWR_WAIT = 3'd0,
      ST_INIT     = 3'd1,
      ST_IDLE     = 3'd2,
      ST_SETUP    = 3'd3,
      ST_PULSE    = 3'd4,
      ST_WAIT     = 3'd5
   } lcd_state_t;

   // HD44780 instruction bytes used by the driver
   localparam logic [7:0] LCD_FUNC_SET = 8'h38;
   localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
   localparam logic [7:0] LCD_CLEAR    = 8'h01;
   localparam logic [7:0] LCD_ENTRY    = 8'h06;
   localparam logic [7:0] LCD_SET_ADDR = 8'h80;

   // Printable character window and the substitute for anything outside it
   localparam logic [7:0] CHAR_MIN     = 8'h20;
   localparam logic [7:0] CHAR_MAX     = 8'h7E;
   localparam logic [7:0] CHAR_REPLACE = 8'h3F;

   localparam int INIT_CMD_COUNT = 4;

   // Power-on init instruction for a given step of the init sequence
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      logic [7:0] cmd;
      case (idx)
         2'd0:    cmd = LCD_FUNC_SET;
         2'd1:    cmd = LCD_DISP_ON;
         2'd2:    cmd = LCD_CLEAR;
         default: cmd = LCD_ENTRY;
      endcase
      return cmd;
   endfunction

   // Non-printable characters are shown as '?'
   function automatic logic [7:0] sanitize_char(input logic [7:0] c);
      return ((c >= CHAR_MIN) && (c <= CHAR_MAX)) ? c : CHAR_REPLACE;
   endfunction

   // Largest of four values, used to size the shared timing counter
   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/q2_lcd_fifo.sv
// Synchronous FIFO with full/empty flags; a push while full is accepted
// when a pop happens in the same cycle.
module q2_lcd_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Storage array is written on accepted pushes only; no reset needed
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because the depth is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/q2_lcd_ctrl.sv
// HD44780 8-bit bus driver fed by q2 output-port writes: decodes the
// command/data encoding, buffers entries, runs power-on init and times the
// E strobe plus the post-transfer settle period.
module q2_lcd_ctrl
   import q2_lcd_pkg::*;
#(
   parameter int POWERON_CYCLES    = 750000,
   parameter int E_PULSE_CYCLES    = 12,
   parameter int CMD_WAIT_CYCLES   = 2000,
   parameter int CLEAR_WAIT_CYCLES = 82000,
   parameter int FIFO_DEPTH        = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr,
   input  logic [11:0] dbus,
   output logic        ready,
   output logic        overflow,
   output logic        lcd_e,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic [7:0]  lcd_d
);

   // One down/up counter serves every timed state, so size it for the longest
   localparam int CNT_MAX = max4(POWERON_CYCLES, E_PULSE_CYCLES,
                                 CMD_WAIT_CYCLES, CLEAR_WAIT_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERON_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(E_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_WAIT_CYCLES - 1);
   localparam logic [1:0]       INIT_LAST  = 2'(INIT_CMD_COUNT - 1);

   lcd_state_t       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [1:0]       init_idx, init_idx_n;
   logic             init_done, init_done_n;
   logic             long_wait, long_wait_n;
   logic             lcd_e_n;
   logic             lcd_rs_n;
   logic [7:0]       lcd_d_n;

   logic             enq_valid;
   logic [8:0]       enq_data;
   logic             fifo_pop;
   logic [8:0]       fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;

   logic             unused_dbus;

   assign unused_dbus = ^dbus[11:9];
   assign lcd_rw      = 1'b0;

   // Translate a port write into a {rs, byte} FIFO entry, or nothing
   always_comb begin
      enq_valid = 1'b0;
      enq_data  = '0;
      if (wr) begin
         if (dbus[8]) begin
            if (dbus[7]) begin
               enq_valid = 1'b1;
               enq_data  = {1'b0, LCD_SET_ADDR | {1'b0, dbus[6:0]}};
            end else if (dbus[0]) begin
               enq_valid = 1'b1;
               enq_data  = {1'b0, LCD_CLEAR};
            end
         end else begin
            enq_valid = 1'b1;
            enq_data  = {1'b1, sanitize_char(dbus[7:0])};
         end
      end
   end

   q2_lcd_fifo #(
      .WIDTH (9),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (enq_valid),
      .pop   (fifo_pop),
      .din   (enq_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Sequencer: power-on delay, init commands, then FIFO entries through SETUP/PULSE/WAIT
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      init_idx_n  = init_idx;
      init_done_n = init_done;
      long_wait_n = long_wait;
      lcd_rs_n    = lcd_rs;
      lcd_d_n     = lcd_d;
      fifo_pop    = 1'b0;
      case (state)
         ST_PWR_WAIT: begin
            if (cnt == PWR_LAST) begin
               state_n = ST_INIT;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_INIT: begin
            lcd_rs_n    = 1'b0;
            lcd_d_n     = init_cmd(init_idx);
            long_wait_n = (init_cmd(init_idx) == LCD_CLEAR);
            state_n     = ST_SETUP;
         end
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               lcd_rs_n    = fifo_dout[8];
               lcd_d_n     = fifo_dout[7:0];
               long_wait_n = !fifo_dout[8] && (fifo_dout[7:0] == LCD_CLEAR);
               state_n     = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_n = ST_PULSE;
            cnt_n   = PULSE_LOAD;
         end
         ST_PULSE: begin
            if (cnt == '0) begin
               state_n = ST_WAIT;
               cnt_n   = long_wait ? CLEAR_LOAD : CMD_LOAD;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               if (init_done) begin
                  state_n = ST_IDLE;
               end else if (init_idx == INIT_LAST) begin
                  init_done_n = 1'b1;
                  state_n     = ST_IDLE;
               end else begin
                  init_idx_n = init_idx + 1'b1;
                  state_n    = ST_INIT;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: begin
            state_n = ST_PWR_WAIT;
            cnt_n   = '0;
         end
      endcase
      lcd_e_n = (state_n == ST_PULSE);
   end

   // State and bus registers; reset drops E at once and restarts power-on
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_PWR_WAIT;
         cnt       <= '0;
         init_idx  <= '0;
         init_done <= 1'b0;
         long_wait <= 1'b0;
         lcd_e     <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_d     <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         init_idx  <= init_idx_n;
         init_done <= init_done_n;
         long_wait <= long_wait_n;
         lcd_e     <= lcd_e_n;
         lcd_rs    <= lcd_rs_n;
         lcd_d     <= lcd_d_n;
      end
   end

   // Status flags: ready follows init completion and FIFO space, overflow is sticky
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         ready <= init_done && !fifo_full;
         if (enq_valid && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule
